// File: rtl/mp3player_audio_pkg.sv
// rtl/mp3player_audio_pkg.sv - shared audio frame constants and I2S transmitter state type
package mp3player_audio_pkg;

  localparam int FRAME_BITS = 32;
  localparam int SAMPLE_W   = 16;
  localparam int BC_W       = $clog2(FRAME_BITS);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } i2s_state_e;

endpackage

// File: rtl/audio_sample_fifo.sv
// rtl/audio_sample_fifo.sv - synchronous first-word-fall-through sample FIFO with level output
module audio_sample_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   wr_en,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LEVEL_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (level == '0);
  assign full    = (level == LEVEL_FULL);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  // Head entry is always visible so the consumer can sample before popping.
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      if (do_wr && !do_rd)      level <= level + 1'b1;
      else if (do_rd && !do_wr) level <= level - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/audio_i2s_tx.sv
// rtl/audio_i2s_tx.sv - I2S transmitter: sample FIFO, BCLK/LRCLK generation and frame serializer
module audio_i2s_tx
  import mp3player_audio_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int BCLK_DIV   = 16
) (
  input  logic                        clk_clk,
  input  logic                        reset_reset,
  input  logic                        enable,
  input  logic                        clear_underrun,
  input  logic [FRAME_BITS-1:0]       snk_data,
  input  logic                        snk_valid,
  output logic                        snk_ready,
  output logic                        i2s_bclk,
  output logic                        i2s_lrclk,
  output logic                        i2s_dacdat,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        underrun,
  output logic [15:0]                 underrun_count
);

  localparam int              DIV_W    = $clog2(BCLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(FRAME_BITS - 1);
  localparam logic [BC_W-1:0]  BC_RIGHT = BC_W'(SAMPLE_W);

  i2s_state_e            state;
  i2s_state_e            state_nxt;
  logic [DIV_W-1:0]      div;
  logic [BC_W-1:0]       bc;
  logic [BC_W-1:0]       bit_idx;
  logic [FRAME_BITS-1:0] frame;
  logic [FRAME_BITS-1:0] fifo_data;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  prev_lsb;
  logic                  div_wrap;
  logic                  bclk_fall;
  logic                  frame_end;
  logic                  load;
  logic                  pop;

  assign snk_ready = !reset_reset && !fifo_full;
  assign div_wrap  = (state == RUN) && (div == DIV_LAST);
  assign bclk_fall = div_wrap && i2s_bclk;
  assign frame_end = bclk_fall && (bc == BC_LAST);
  assign pop       = load && !fifo_empty;

  audio_sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FRAME_BITS)
  ) u_fifo (
    .clk     (clk_clk),
    .rst     (reset_reset),
    .wr_data (snk_data),
    .wr_en   (snk_valid && snk_ready),
    .rd_en   (pop),
    .rd_data (fifo_data),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .level   (fifo_level)
  );

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) state <= IDLE;
    else             state <= state_nxt;
  end

  // Stopping is only honoured on the last falling edge of a frame.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          state_nxt = RUN;
          load      = 1'b1;
        end
      end
      RUN: begin
        if (frame_end) begin
          if (enable) load      = 1'b1;
          else        state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      div      <= '0;
      i2s_bclk <= 1'b0;
      bc       <= '0;
      prev_lsb <= 1'b0;
    end else if (state == IDLE) begin
      div      <= '0;
      i2s_bclk <= 1'b0;
      bc       <= '0;
      prev_lsb <= 1'b0;
    end else if (div_wrap) begin
      div      <= '0;
      i2s_bclk <= ~i2s_bclk;
      if (i2s_bclk) bc <= bc + 1'b1;
      // R[0] spills into slot 0 of the next frame, silent when stopping.
      if (frame_end) prev_lsb <= enable & frame[0];
    end else begin
      div <= div + 1'b1;
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      frame          <= '0;
      underrun       <= 1'b0;
      underrun_count <= '0;
    end else begin
      if (load) frame <= fifo_empty ? '0 : fifo_data;
      if (load && fifo_empty) begin
        underrun <= 1'b1;
        if (clear_underrun)                underrun_count <= 16'd1;
        else if (underrun_count != 16'hFFFF) underrun_count <= underrun_count + 16'd1;
      end else if (clear_underrun) begin
        underrun       <= 1'b0;
        underrun_count <= '0;
      end
    end
  end

  // Slot k carries frame bit k-1 (MSB first), which sits at index FRAME_BITS-k.
  assign bit_idx    = BC_W'(0) - bc;
  assign i2s_lrclk  = (bc >= BC_RIGHT);
  assign i2s_dacdat = (state == RUN) && ((bc == '0) ? prev_lsb : frame[bit_idx]);

endmodule

// File: tb/tb_audio_i2s_tx.sv
// tb/tb_audio_i2s_tx.sv - self-checking bench for audio_i2s_tx against a serial bit-stream model
module tb_audio_i2s_tx;

  localparam int FIFO_DEPTH = 8;
  localparam int BCLK_DIV   = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        clear_underrun = 1'b0;
  logic        snk_valid = 1'b0;
  logic [31:0] snk_data = '0;
  logic        snk_ready;
  logic        i2s_bclk;
  logic        i2s_lrclk;
  logic        i2s_dacdat;
  logic [3:0]  fifo_level;
  logic        underrun;
  logic [15:0] underrun_count;

  int pass_cnt = 0;
  int check_cnt = 0;
  int cyc = 0;
  int falls = 0;
  int accepts;
  int c0;
  int bad;
  bit bclk_q = 1'b0;
  bit lr_q = 1'b0;
  bit exp_accept;
  bit pre_ready;
  logic [15:0] lw;
  logic [15:0] rw;

  bit          cap_bits[$];
  bit          cap_lr[$];
  bit          exp_bits[$];
  int          rise_cyc[$];
  int          fall_cyc[$];
  int          lr_rise_cyc[$];
  int          lr_fall_cyc[$];
  logic [31:0] model_q[$];

  typedef struct {
    bit valid;
    int exp_level;
    bit exp_ready;
  } fifo_vec_t;
  fifo_vec_t vecs[10];

  always #5 clk = ~clk;

  audio_i2s_tx #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .BCLK_DIV   (BCLK_DIV)
  ) dut (
    .clk_clk        (clk),
    .reset_reset    (rst),
    .enable         (enable),
    .clear_underrun (clear_underrun),
    .snk_data       (snk_data),
    .snk_valid      (snk_valid),
    .snk_ready      (snk_ready),
    .i2s_bclk       (i2s_bclk),
    .i2s_lrclk      (i2s_lrclk),
    .i2s_dacdat     (i2s_dacdat),
    .fifo_level     (fifo_level),
    .underrun       (underrun),
    .underrun_count (underrun_count)
  );

  always begin
    @(posedge clk);
    cyc++;
    #1;
    if (i2s_bclk && !bclk_q) begin
      cap_bits.push_back(i2s_dacdat);
      cap_lr.push_back(i2s_lrclk);
      rise_cyc.push_back(cyc);
    end
    if (!i2s_bclk && bclk_q) begin
      falls++;
      fall_cyc.push_back(cyc);
    end
    if (i2s_lrclk && !lr_q) lr_rise_cyc.push_back(cyc);
    if (!i2s_lrclk && lr_q) lr_fall_cyc.push_back(cyc);
    bclk_q = i2s_bclk;
    lr_q   = i2s_lrclk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time %0t reached, required finish before it", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_capture();
    cap_bits.delete();
    cap_lr.delete();
    rise_cyc.delete();
    fall_cyc.delete();
    lr_rise_cyc.delete();
    lr_fall_cyc.delete();
    falls = 0;
  endtask

  task automatic push_word(input logic [31:0] w);
    snk_valid = 1'b1;
    snk_data  = w;
    step();
    snk_valid = 1'b0;
    model_q.push_back(w);
  endtask

  task automatic run_until_falls(input string name, input int target);
    int n = 0;
    while (falls < target && n < target * 2 * BCLK_DIV + 4 * BCLK_DIV) begin
      step();
      n++;
    end
    chk({name, "_reach_falls"}, falls, target);
  endtask

  task automatic run_frames(input string name, input int frames, input int drop_bc);
    run_until_falls(name, (frames - 1) * 32 + drop_bc);
    enable = 1'b0;
    repeat ((32 - drop_bc + 2) * 2 * BCLK_DIV) step();
    chk({name, "_total_falls"}, falls, frames * 32);
    chk({name, "_idle_outputs"}, {i2s_bclk, i2s_lrclk, i2s_dacdat}, 3'b000);
  endtask

  // Stream seen on BCLK rising edges: one leading 0, then every loaded frame MSB first.
  task automatic build_expected(input int frames);
    exp_bits.delete();
    exp_bits.push_back(1'b0);
    for (int f = 0; f < frames; f++) begin
      logic [31:0] w;
      if (model_q.size() > 0) w = model_q.pop_front();
      else                    w = '0;
      for (int b = 31; b >= 0; b--) exp_bits.push_back(w[b]);
    end
  endtask

  task automatic compare_stream(input string name, input int nbits);
    int nbad = 0;
    chk({name, "_rises"}, cap_bits.size(), nbits);
    if (cap_bits.size() >= nbits) begin
      for (int j = 0; j < nbits; j++) begin
        if (cap_bits[j] !== exp_bits[j]) nbad++;
        if (cap_lr[j] !== ((j % 32) >= 16)) nbad++;
      end
    end
    chk({name, "_stream_errors"}, nbad, 0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 1, 1'b1};
    vecs[1] = '{1'b1, 2, 1'b1};
    vecs[2] = '{1'b0, 2, 1'b1};
    vecs[3] = '{1'b1, 3, 1'b1};
    vecs[4] = '{1'b1, 4, 1'b1};
    vecs[5] = '{1'b1, 5, 1'b1};
    vecs[6] = '{1'b1, 6, 1'b1};
    vecs[7] = '{1'b1, 7, 1'b1};
    vecs[8] = '{1'b1, 8, 1'b0};
    vecs[9] = '{1'b1, 8, 1'b0};

    repeat (3) step();
    chk("rst_snk_ready", snk_ready, 0);
    chk("rst_fifo_level", fifo_level, 0);
    chk("rst_i2s_pins", {i2s_bclk, i2s_lrclk, i2s_dacdat}, 3'b000);
    chk("rst_underrun", underrun, 0);
    chk("rst_underrun_count", underrun_count, 0);
    rst = 1'b0;
    step();
    chk("release_snk_ready", snk_ready, 1);

    // FIFO fill with enable low, word 0 is the known pattern
    accepts = 0;
    for (int i = 0; i < 10; i++) begin
      snk_valid  = vecs[i].valid;
      snk_data   = (i == 0) ? 32'h8001_7FFE : $urandom;
      pre_ready  = (i == 0) ? 1'b1 : vecs[i-1].exp_ready;
      exp_accept = vecs[i].valid && pre_ready;
      #3;
      if (snk_valid && snk_ready) accepts++;
      if (exp_accept) model_q.push_back(snk_data);
      step();
      chk($sformatf("vec%0d_fifo_level", i), fifo_level, vecs[i].exp_level);
      chk($sformatf("vec%0d_snk_ready", i), snk_ready, vecs[i].exp_ready);
    end
    snk_valid = 1'b0;
    chk("full_accepts", accepts, 8);

    // Four frames, enable dropped at bc=5 of the fourth
    clear_capture();
    c0 = cyc;
    enable = 1'b1;
    run_frames("b", 4, 5);
    build_expected(4);
    compare_stream("b", 128);
    if (cap_bits.size() >= 33) begin
      for (int k = 1; k <= 16; k++)  lw = {lw[14:0], cap_bits[k]};
      for (int k = 17; k <= 32; k++) rw = {rw[14:0], cap_bits[k]};
      chk("b_left_slot", lw, 16'h8001);
      chk("b_right_slot", rw, 16'h7FFE);
    end
    chk("b_lrclk_rises", lr_rise_cyc.size(), 4);
    if (rise_cyc.size() >= 128 && fall_cyc.size() >= 128 && lr_rise_cyc.size() >= 4 &&
        lr_fall_cyc.size() >= 4) begin
      chk("b_first_rise_latency", rise_cyc[0] - c0, BCLK_DIV + 1);
      chk("b_bclk_period", rise_cyc[1] - rise_cyc[0], 2 * BCLK_DIV);
      chk("b_bclk_high", fall_cyc[0] - rise_cyc[0], BCLK_DIV);
      chk("b_lrclk_period", lr_rise_cyc[1] - lr_rise_cyc[0], 64 * BCLK_DIV);
      chk("b_lrclk_high", lr_fall_cyc[0] - lr_rise_cyc[0], 32 * BCLK_DIV);
      bad = 0;
      for (int j = 1; j < 128; j++) if (rise_cyc[j] - rise_cyc[j-1] != 2 * BCLK_DIV) bad++;
      for (int j = 0; j < 128; j++) if (fall_cyc[j] - rise_cyc[j] != BCLK_DIV) bad++;
      for (int j = 1; j < 4; j++) if (lr_rise_cyc[j] - lr_rise_cyc[j-1] != 64 * BCLK_DIV) bad++;
      for (int j = 0; j < 4; j++) if (lr_fall_cyc[j] - lr_rise_cyc[j] != 32 * BCLK_DIV) bad++;
      chk("b_clock_shape_errors", bad, 0);
    end
    chk("b_fifo_level", fifo_level, model_q.size());
    chk("b_underrun", underrun, 0);

    // Single frame, enable dropped at bc=5: exactly one pop
    clear_capture();
    enable = 1'b1;
    run_frames("c", 1, 5);
    build_expected(1);
    compare_stream("c", 32);
    chk("c_fifo_level", fifo_level, model_q.size());
    chk("c_underrun_count", underrun_count, 0);

    // Random words drained past empty: last frame is an underrun
    push_word($urandom);
    push_word($urandom);
    clear_capture();
    enable = 1'b1;
    run_frames("d", 6, 3);
    build_expected(6);
    compare_stream("d", 192);
    chk("d_underrun", underrun, 1);
    chk("d_underrun_count", underrun_count, 1);
    chk("d_fifo_level", fifo_level, 0);

    clear_underrun = 1'b1;
    step();
    clear_underrun = 1'b0;
    chk("e_cleared_underrun", underrun, 0);
    chk("e_cleared_count", underrun_count, 0);

    // Three frames from an empty FIFO
    clear_capture();
    enable = 1'b1;
    run_frames("e", 3, 5);
    build_expected(3);
    compare_stream("e", 96);
    chk("e_underrun", underrun, 1);
    chk("e_underrun_count", underrun_count, 3);

    // Clear coinciding with a fresh underrun load
    clear_capture();
    enable = 1'b1;
    clear_underrun = 1'b1;
    step();
    clear_underrun = 1'b0;
    enable = 1'b0;
    chk("f_underrun", underrun, 1);
    chk("f_underrun_count", underrun_count, 1);
    run_until_falls("f", 32);
    repeat (4 * BCLK_DIV) step();
    chk("f_total_falls", falls, 32);
    chk("f_count_after_frame", underrun_count, 1);

    // Reset in the middle of a right-channel slot
    push_word(32'hFFFF_FFFF);
    clear_capture();
    enable = 1'b1;
    run_until_falls("g", 20);
    repeat (BCLK_DIV + 2) step();
    chk("g_pre_reset_pins", {i2s_bclk, i2s_lrclk, i2s_dacdat}, 3'b111);
    rst = 1'b1;
    #1;
    chk("g_reset_pins", {i2s_bclk, i2s_lrclk, i2s_dacdat}, 3'b000);
    chk("g_reset_snk_ready", snk_ready, 0);
    chk("g_reset_underrun", {underrun, underrun_count}, 17'd0);
    model_q.delete();
    step();
    chk("g_reset_fifo_level", fifo_level, 0);
    enable = 1'b0;
    rst = 1'b0;
    step();
    chk("g_release_snk_ready", snk_ready, 1);
    chk("g_release_pins", {i2s_bclk, i2s_lrclk, i2s_dacdat}, 3'b000);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/audio_i2s_tx.md
AUDIO_I2S_TX -- requirements
Module: audio_i2s_tx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8: sample FIFO entries (power of two).
REQ-002 SHALL have parameter BCLK_DIV, default 16: clk cycles per BCLK half-period (>=2).
REQ-003 SHALL have port clk_clk  in  1: single clock for all logic.
REQ-004 SHALL have port reset_reset  in  1: asynchronous, active-high reset.
REQ-005 SHALL have port enable  in  1: run request.
REQ-006 SHALL have port clear_underrun  in  1: one-cycle pulse clearing underrun status.
REQ-007 SHALL have port snk_data  in  32: stereo word, [31:16] left, [15:0] right, two's complement.
REQ-008 SHALL have port snk_valid  in  1: snk_data valid.
REQ-009 SHALL have port snk_ready  out  1: FIFO can accept.
REQ-010 SHALL have port i2s_bclk  out  1: bit clock to codec.
REQ-011 SHALL have port i2s_lrclk  out  1: word select, 0 = left, 1 = right.
REQ-012 SHALL have port i2s_dacdat  out  1: serial data, MSB first.
REQ-013 SHALL have port fifo_level  out  $clog2(FIFO_DEPTH)+1: occupied entries.
REQ-014 SHALL have port underrun  out  1: sticky underrun flag.
REQ-015 SHALL have port underrun_count  out  16: saturating count of underrun frames.

Function
REQ-016 SHALL accept a word on every cycle with snk_valid and snk_ready both high; snk_ready = (fifo_level < FIFO_DEPTH), independent of snk_valid.
REQ-017 SHALL update fifo_level one cycle after push/pop; simultaneous push and pop leave it unchanged; push while full is impossible by REQ-016.
REQ-018 SHALL implement states IDLE and RUN; IDLE -> RUN on enable=1; RUN -> IDLE only at a frame boundary (bit counter 31 -> 0 with enable=0).
REQ-019 SHALL in IDLE hold i2s_bclk=0, i2s_lrclk=0, i2s_dacdat=0, divider and bit counter at 0, no FIFO pops.
REQ-020 SHALL in RUN count divider 0..BCLK_DIV-1 and toggle i2s_bclk on wrap; first rising edge BCLK_DIV cycles after entering RUN.
REQ-021 SHALL advance bit counter bc (0..31, wraps) on each BCLK falling edge; i2s_lrclk = (bc >= 16), changing on the falling edge.
REQ-022 SHALL load the frame register ({L,R}) on entering RUN and at every bc 31 -> 0 transition that remains in RUN, popping one FIFO word.
REQ-023 SHALL, if the FIFO is empty at load, load 32'h0, set underrun, increment underrun_count (saturating at 16'hFFFF).
REQ-024 SHALL drive i2s_dacdat with a one-BCLK I2S delay: at bc=k, frame bit (k-1) where frame bit 0 = L[15]; at bc=0, previous frame's R[0] (0 for the first frame after IDLE).
REQ-025 SHALL, when clear_underrun coincides with a new underrun, leave underrun=1 and underrun_count=1.
REQ-026 SHALL leave FIFO contents intact across RUN -> IDLE -> RUN.
REQ-027 SHALL ignore enable deassertion mid-frame until the frame completes.

Reset
REQ-028 SHALL on reset_reset=1 immediately force IDLE, empty FIFO, fifo_level=0, snk_ready=0 during reset, i2s_bclk=0, i2s_lrclk=0, i2s_dacdat=0, underrun=0, underrun_count=0.
REQ-029 SHALL raise snk_ready the first cycle after reset release; reset mid-frame truncates output with no glitch beyond forcing outputs low.

Structure
REQ-030 SHALL take FRAME_BITS=32, SAMPLE_W=16 and the state enum from shared package mp3player_audio_pkg.
REQ-031 SHALL instantiate sub-module audio_sample_fifo (synchronous FIFO, first-word-fall-through, level output).

Verification
REQ-032 SHALL test: reset, push 32'h8001_7FFE, enable=1 -> left slot bits 1000_0000_0000_0001 at bc=1..16, right 0111_1111_1111_1110 at bc=17..32(=0).
REQ-033 SHALL test: enable with empty FIFO for 3 frames -> dacdat all 0, underrun=1, underrun_count=3.
REQ-034 SHALL test: snk_valid held high, enable=0 -> exactly 8 accepts, snk_ready=0, fifo_level=8.
REQ-035 SHALL test: enable dropped at bc=5 -> 27 more falling edges, then IDLE, outputs 0, one word popped.
REQ-036 SHALL test: clear_underrun on the cycle of an underrun load -> underrun=1, underrun_count=1.
REQ-037 SHALL test: BCLK_DIV=16 -> BCLK period 32 clk cycles, LRCLK period 1024 clk cycles, 50% duty.
